// File: rtl/pyramid_level_scheduler_if.sv
// pyramid_level_scheduler_if: control/status bundle between the frame sequencer and its host.
interface pyramid_level_scheduler_if;
  logic        enable;
  logic        vsync_in;
  logic [2:0]  level_done;
  logic [2:0]  level_start;
  logic [1:0]  active_level;
  logic        busy;
  logic        first_frame;
  logic        track_ok;
  logic        track_lost;
  logic        protocol_err;
  logic [15:0] frames_ok_cnt;
  logic [15:0] frames_lost_cnt;
  modport master (
    output enable, vsync_in, level_done,
    input  level_start, active_level, busy, first_frame, track_ok, track_lost, protocol_err,
           frames_ok_cnt, frames_lost_cnt
  );
  modport slave (
    input  enable, vsync_in, level_done,
    output level_start, active_level, busy, first_frame, track_ok, track_lost, protocol_err,
           frames_ok_cnt, frames_lost_cnt
  );
endinterface

// File: rtl/pyramid_level_scheduler.sv
// pyramid_level_scheduler: per-frame L2->L1->L0 start sequencer with watchdog and ok/lost reporting.
// Define PYRAMID_SCHED_STATS_EN to add saturating ok/lost frame counters.
module pyramid_level_scheduler #(
  parameter int TIMEOUT_CYCLES = 2475000,
  parameter int TIMEOUT_W      = 22,
  parameter int SKIP_FIRST     = 1
) (
  input logic                      rx_pclk,
  input logic                      reset_n,
  pyramid_level_scheduler_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ARM, RUN_L2, RUN_L1, RUN_L0, DONE, LOST} state_t;
  state_t               state;
  logic                 vsync_q;
  logic [TIMEOUT_W-1:0] wd;
  logic                 rise, done_cur, final_done, timeout;
  logic [2:0]           cur;
  always_comb begin
    rise       = bus.vsync_in & ~vsync_q;
    cur        = bus.busy ? 3'b001 << bus.active_level : 3'b000;
    done_cur   = |(bus.level_done & cur);
    final_done = done_cur & (state == RUN_L0);
    timeout    = wd == TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  end
  always_ff @(posedge rx_pclk) begin
    if (!reset_n) begin
      state            <= IDLE;
      vsync_q          <= 1'b0;
      wd               <= '0;
      bus.level_start  <= '0;
      bus.active_level <= 2'd3;
      bus.busy         <= 1'b0;
      bus.first_frame  <= 1'b0;
      bus.track_ok     <= 1'b0;
      bus.track_lost   <= 1'b0;
      bus.protocol_err <= 1'b0;
    end else begin
      vsync_q          <= bus.vsync_in;
      bus.level_start  <= '0;
      bus.track_ok     <= 1'b0;
      bus.track_lost   <= 1'b0;
      bus.protocol_err <= bus.protocol_err | (|(bus.level_done & ~cur));
      if (!bus.enable) begin
        state            <= IDLE;
        bus.busy         <= 1'b0;
        bus.active_level <= 2'd3;
        bus.first_frame  <= 1'b0;
      end else if (state == IDLE) begin
        state           <= ARM;
        bus.first_frame <= SKIP_FIRST != 0;
      end else if (state inside {ARM, DONE, LOST}) begin
        state           <= rise && !bus.first_frame ? RUN_L2 : ARM;
        bus.first_frame <= bus.first_frame & ~rise;
        if (rise && !bus.first_frame) begin
          bus.level_start  <= 3'b100;
          bus.active_level <= 2'd2;
          bus.busy         <= 1'b1;
          wd               <= '0;
        end
      end else if (rise) begin
        // frame overrun: a coinciding final done still counts as success
        state            <= RUN_L2;
        bus.level_start  <= 3'b100;
        bus.active_level <= 2'd2;
        bus.busy         <= 1'b1;
        wd               <= '0;
        bus.track_ok     <= final_done;
        bus.track_lost   <= ~final_done;
      end else if (final_done) begin
        state            <= DONE;
        bus.track_ok     <= 1'b1;
        bus.busy         <= 1'b0;
        bus.active_level <= 2'd3;
      end else if (done_cur) begin
        state            <= state == RUN_L2 ? RUN_L1 : RUN_L0;
        bus.level_start  <= cur >> 1;
        bus.active_level <= bus.active_level - 2'd1;
        wd               <= '0;
      end else if (timeout) begin
        state            <= LOST;
        bus.track_lost   <= 1'b1;
        bus.busy         <= 1'b0;
        bus.active_level <= 2'd3;
      end else begin
        wd <= &wd ? wd : wd + 1'b1;
      end
    end
  end
`ifdef PYRAMID_SCHED_STATS_EN
  always_ff @(posedge rx_pclk) begin
    if (!reset_n) begin
      bus.frames_ok_cnt   <= '0;
      bus.frames_lost_cnt <= '0;
    end else begin
      if (bus.track_ok && !(&bus.frames_ok_cnt)) bus.frames_ok_cnt <= bus.frames_ok_cnt + 16'd1;
      if (bus.track_lost && !(&bus.frames_lost_cnt)) bus.frames_lost_cnt <= bus.frames_lost_cnt + 16'd1;
    end
  end
`else
  always_comb begin
    bus.frames_ok_cnt   = '0;
    bus.frames_lost_cnt = '0;
  end
`endif
endmodule

// File: tb/tb_pyramid_level_scheduler.sv
// tb_pyramid_level_scheduler: directed + randomized frame sequences checked against an event-timeline model.
module tb_pyramid_level_scheduler;
  localparam int TO = 500;
`ifdef PYRAMID_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  typedef struct {int c; logic [2:0] v;} ev_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   exp_nok = 0;
  int   exp_nlost = 0;
  ev_t  obs_st[$], exp_st[$];
  int   obs_ok[$], exp_ok[$], obs_lost[$], exp_lost[$];

  pyramid_level_scheduler_if bus();
  pyramid_level_scheduler #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(10), .SKIP_FIRST(1)) dut (
    .rx_pclk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // event monitor sampled mid-cycle
  always @(negedge clk) if (cyc > 0) begin
    if (bus.level_start !== 3'b000) obs_st.push_back('{cyc, bus.level_start});
    if (bus.track_ok === 1'b1) obs_ok.push_back(cyc);
    if (bus.track_lost === 1'b1) obs_lost.push_back(cyc);
    if (bus.track_ok === 1'b1 || bus.track_lost === 1'b1)
      chk("ok_lost_excl", 32'(bus.track_ok & bus.track_lost), 0);
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: observed cycle %0d expected finish", cyc);
    $fatal(1);
  end

  task automatic go_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic vrise(output int r);
    r = cyc;
    bus.vsync_in = 1'b1;
    go_to(r + 1);
    bus.vsync_in = 1'b0;
  endtask

  task automatic pulse(input int c, input logic [2:0] v);
    go_to(c);
    bus.level_done = v;
    go_to(c + 1);
    bus.level_done = 3'b000;
  endtask

  task automatic push_st(input int c, input logic [2:0] v);
    exp_st.push_back('{c, v});
  endtask

  task automatic push_ok(input int c);
    exp_ok.push_back(c);
    exp_nok++;
  endtask

  task automatic push_lost(input int c);
    exp_lost.push_back(c);
    exp_nlost++;
  endtask

  // full L2/L1/L0 run: each start follows the previous done by one cycle
  task automatic levels(input int s2, input int d2, input int d1, input int d0, output int okc);
    int s1, s0;
    s1  = s2 + d2 + 1;
    s0  = s1 + d1 + 1;
    okc = s0 + d0 + 1;
    push_st(s2, 3'b100);
    push_st(s1, 3'b010);
    push_st(s0, 3'b001);
    push_ok(okc);
    pulse(s2 + d2, 3'b100);
    pulse(s1 + d1, 3'b010);
    pulse(s0 + d0, 3'b001);
  endtask

  task automatic compare(input string tag);
    chk($sformatf("%s_nstart", tag), obs_st.size(), exp_st.size());
    for (int i = 0; i < exp_st.size() && i < obs_st.size(); i++) begin
      chk($sformatf("%s_start%0d_cyc", tag, i), obs_st[i].c, exp_st[i].c);
      chk($sformatf("%s_start%0d_val", tag, i), 32'(obs_st[i].v), 32'(exp_st[i].v));
    end
    chk($sformatf("%s_nok", tag), obs_ok.size(), exp_ok.size());
    for (int i = 0; i < exp_ok.size() && i < obs_ok.size(); i++)
      chk($sformatf("%s_ok%0d_cyc", tag, i), obs_ok[i], exp_ok[i]);
    chk($sformatf("%s_nlost", tag), obs_lost.size(), exp_lost.size());
    for (int i = 0; i < exp_lost.size() && i < obs_lost.size(); i++)
      chk($sformatf("%s_lost%0d_cyc", tag, i), obs_lost[i], exp_lost[i]);
    obs_st.delete(); exp_st.delete();
    obs_ok.delete(); exp_ok.delete();
    obs_lost.delete(); exp_lost.delete();
  endtask

  task automatic check_cnts(input string tag);
    chk($sformatf("%s_ok_cnt", tag), 32'(bus.frames_ok_cnt), STATS ? exp_nok : 0);
    chk($sformatf("%s_lost_cnt", tag), 32'(bus.frames_lost_cnt), STATS ? exp_nlost : 0);
  endtask

  task automatic frame(input string tag, input int d2, input int d1, input int d0);
    int r, okc;
    vrise(r);
    levels(r + 1, d2, d1, d0, okc);
    go_to(okc);
    chk($sformatf("%s_busy", tag), 32'(bus.busy), 0);
    chk($sformatf("%s_active", tag), 32'(bus.active_level), 3);
    go_to(okc + 2);
    compare(tag);
  endtask

  initial begin
    int r, r2, s1, s0, okc, e, d2, d1, d0;
    bus.enable     = 1'b1;
    bus.vsync_in   = 1'b0;
    bus.level_done = 3'b000;
    for (int i = 0; i < 3; i++) begin
      bus.vsync_in = (i % 2) == 0;
      go_to(i + 1);
    end
    chk("rst_start", 32'(bus.level_start), 0);
    chk("rst_active", 32'(bus.active_level), 3);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_first", 32'(bus.first_frame), 0);
    chk("rst_ok", 32'(bus.track_ok), 0);
    chk("rst_lost", 32'(bus.track_lost), 0);
    chk("rst_perr", 32'(bus.protocol_err), 0);
    check_cnts("rst");
    compare("rst");
    bus.vsync_in = 1'b0;
    reset_n = 1'b1;
    go_to(cyc + 1);
    chk("arm_first", 32'(bus.first_frame), 1);
    go_to(cyc + 6);
    vrise(r);
    go_to(r + 3);
    chk("skip_first_clr", 32'(bus.first_frame), 0);
    compare("skip");

    go_to(cyc + 5);
    frame("basic", 100, 250, 400);
    check_cnts("basic");

    for (int i = 0; i < 4; i++) begin
      go_to(cyc + 3 + int'($urandom_range(0, 20)));
      frame($sformatf("rnd%0d", i), int'($urandom_range(0, TO - 1)),
            int'($urandom_range(0, TO - 1)), int'($urandom_range(0, TO - 1)));
    end
    go_to(cyc + 4);
    frame("edge", TO - 1, 0, TO - 1);

    // watchdog: L1 never completes
    go_to(cyc + 4);
    vrise(r);
    d2 = int'($urandom_range(0, 50));
    s1 = r + 1 + d2 + 1;
    push_st(r + 1, 3'b100);
    push_st(s1, 3'b010);
    push_lost(s1 + TO);
    pulse(r + 1 + d2, 3'b100);
    go_to(s1 + TO - 1);
    chk("to_early", 32'(bus.track_lost), 0);
    go_to(s1 + TO);
    chk("to_lost", 32'(bus.track_lost), 1);
    chk("to_busy", 32'(bus.busy), 0);
    chk("to_active", 32'(bus.active_level), 3);
    go_to(s1 + TO + 3);
    compare("timeout");
    check_cnts("timeout");

    // overrun while L1 runs
    go_to(cyc + 4);
    vrise(r);
    d2 = int'($urandom_range(0, 40));
    s1 = r + 1 + d2 + 1;
    push_st(r + 1, 3'b100);
    push_st(s1, 3'b010);
    pulse(r + 1 + d2, 3'b100);
    go_to(s1 + int'($urandom_range(1, 100)));
    vrise(r2);
    push_lost(r2 + 1);
    levels(r2 + 1, int'($urandom_range(0, 60)), int'($urandom_range(0, 60)), int'($urandom_range(0, 60)), okc);
    go_to(okc + 2);
    compare("ovr_l1");

    // overrun coinciding with the final done
    go_to(cyc + 4);
    vrise(r);
    d2 = int'($urandom_range(0, 40));
    d1 = int'($urandom_range(0, 40));
    d0 = int'($urandom_range(0, 40));
    s1 = r + 1 + d2 + 1;
    s0 = s1 + d1 + 1;
    push_st(r + 1, 3'b100);
    push_st(s1, 3'b010);
    push_st(s0, 3'b001);
    pulse(r + 1 + d2, 3'b100);
    pulse(s1 + d1, 3'b010);
    go_to(s0 + d0);
    bus.level_done = 3'b001;
    vrise(r2);
    bus.level_done = 3'b000;
    push_ok(r2 + 1);
    levels(r2 + 1, int'($urandom_range(0, 60)), int'($urandom_range(0, 60)), int'($urandom_range(0, 60)), okc);
    go_to(okc + 2);
    compare("ovr_l0");
    check_cnts("ovr");

    // wrong-level done during L2
    go_to(cyc + 4);
    chk("perr_before", 32'(bus.protocol_err), 0);
    vrise(r);
    go_to(r + 6);
    bus.level_done = 3'b001;
    go_to(r + 7);
    bus.level_done = 3'b000;
    chk("perr_set", 32'(bus.protocol_err), 1);
    chk("perr_active", 32'(bus.active_level), 2);
    chk("perr_busy", 32'(bus.busy), 1);
    levels(r + 1, 20, 5, 5, okc);
    go_to(okc + 2);
    chk("perr_sticky", 32'(bus.protocol_err), 1);
    compare("perr");

    // enable drop during L0, then buffer-fill frame again
    go_to(cyc + 4);
    vrise(r);
    d2 = int'($urandom_range(0, 30));
    d1 = int'($urandom_range(0, 30));
    s1 = r + 1 + d2 + 1;
    s0 = s1 + d1 + 1;
    push_st(r + 1, 3'b100);
    push_st(s1, 3'b010);
    push_st(s0, 3'b001);
    pulse(r + 1 + d2, 3'b100);
    pulse(s1 + d1, 3'b010);
    e = s0 + 10;
    go_to(e);
    bus.enable = 1'b0;
    go_to(e + 1);
    chk("dis_busy", 32'(bus.busy), 0);
    chk("dis_active", 32'(bus.active_level), 3);
    chk("dis_first", 32'(bus.first_frame), 0);
    go_to(e + 5);
    bus.enable = 1'b1;
    go_to(e + 6);
    chk("reen_first", 32'(bus.first_frame), 1);
    compare("en_drop");
    go_to(e + 10);
    vrise(r);
    go_to(r + 3);
    chk("refill_clr", 32'(bus.first_frame), 0);
    compare("refill");
    go_to(cyc + 5);
    frame("after_refill", int'($urandom_range(0, 80)), int'($urandom_range(0, 80)), int'($urandom_range(0, 80)));
    go_to(cyc + 3);
    check_cnts("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
